// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide sequencer owning HI/LO for the MIPS EX stage.
// Optional MDU_ZERO_SKIP_EN short-circuits trivially-zero operations.
module mdu_ctrl #(
  parameter int WIDTH           = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] sr,
  input  logic [WIDTH-1:0] tg,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / STEPS_PER_CYCLE;
  localparam int CW = $clog2(N);
  localparam int PW = 2 * WIDTH + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   p_q, p_d, p_step;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            div_q, div_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;
  logic            div0_q, div0_d;
  logic            zero_q, zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic             a_sgn, b_sgn, skip;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] quo_s, rem_s;

  // Multiply: shift-add, multiplier in low half, partial sum in upper W+1.
  // Divide: restoring, remainder in upper W+1, quotient shifts in from below.
  function automatic logic [PW-1:0] one_step(
    input logic [PW-1:0]    p,
    input logic [WIDTH-1:0] b,
    input logic             dv
  );
    logic [WIDTH:0]   r;
    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] q;
    logic [PW-1:0]    t;
    if (dv) begin
      r = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
      q = {p[WIDTH-2:0], 1'b0};
      if (r >= {1'b0, b}) begin
        r = r - {1'b0, b};
        q[0] = 1'b1;
      end
      t = {r, q};
    end else begin
      s = p[2*WIDTH:WIDTH] + (p[0] ? {1'b0, b} : '0);
      t = {s, p[WIDTH-1:0]};
      t = t >> 1;
    end
    return t;
  endfunction

  assign a_sgn = op[0] & sr[WIDTH-1];
  assign b_sgn = op[0] & tg[WIDTH-1];
  assign a_mag = a_sgn ? -sr : sr;
  assign b_mag = b_sgn ? -tg : tg;

`ifdef MDU_ZERO_SKIP_EN
  assign skip = op[1] ? (sr == '0 && tg != '0)
                      : (sr == '0 || tg == '0);
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    p_step = p_q;
    for (int i = 0; i < STEPS_PER_CYCLE; i++)
      p_step = one_step(p_step, b_q, div_q);
  end

  always_comb begin
    prod_s = neg_q ? -p_q[2*WIDTH-1:0] : p_q[2*WIDTH-1:0];
    quo_s  = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    rem_s  = rneg_q ? -p_q[2*WIDTH-1:WIDTH]
                    : p_q[2*WIDTH-1:WIDTH];
    res_hi = prod_s[2*WIDTH-1:WIDTH];
    res_lo = prod_s[WIDTH-1:0];
    if (zero_q) begin
      res_hi = '0;
      res_lo = '0;
    end else if (div_q) begin
      res_hi = rem_s;
      res_lo = div0_q ? '1 : quo_s;
    end
  end

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    div0_d  = div0_q;
    zero_d  = zero_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          div_d   = op[1];
          neg_d   = a_sgn ^ b_sgn;
          rneg_d  = a_sgn;
          div0_d  = op[1] & (tg == '0);
          zero_d  = skip;
          cnt_d   = '0;
          b_d     = op[1] ? b_mag : a_mag;
          p_d     = {{(WIDTH+1){1'b0}},
                     op[1] ? a_mag : b_mag};
          state_d = skip ? FIX : CALC;
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      CALC: begin
        p_d   = p_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        hi_d    = res_hi;
        lo_d    = res_lo;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
      zero_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      div0_q  <= div0_d;
      zero_q  <= zero_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed vector bench for mdu_ctrl (WIDTH=32, one step per cycle).
// Vector table plus hand sequences for moves, busy-start and reset.
module tb_mdu_ctrl;

  localparam int W    = 32;
  localparam int FULL = 33;

  logic         clk = 1'b0;
  logic         rst, start, mthi, mtlo;
  logic [1:0]   op;
  logic [W-1:0] sr, tg, wdata, hi, lo;
  logic         busy, done;

  int applied     = 0;
  int miscompares = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] sr;
    logic [W-1:0] tg;
    logic [W-1:0] e_hi;
    logic [W-1:0] e_lo;
    bit           skip;
  } vec_t;

  vec_t vt[15];

  mdu_ctrl #(.WIDTH(W), .STEPS_PER_CYCLE(1)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .sr    (sr),
    .tg    (tg),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [W-1:0] act,
                     input logic [W-1:0] req);
    applied++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic int lat_of(input bit skip);
`ifdef MDU_ZERO_SKIP_EN
    return skip ? 1 : FULL;
`else
    return skip ? FULL : FULL;
`endif
  endfunction

  // Drive a start at a negedge; returns at the negedge after E0.
  task automatic issue(input logic [1:0] o,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    sr    = a;
    tg    = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_result(input string name,
                             input int lat,
                             input int n0,
                             input logic [W-1:0] e_hi,
                             input logic [W-1:0] e_lo);
    int n;
    int nb;
    n  = n0;
    nb = n0;
    while (!done && n < 200) begin
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, W'(n), W'(lat));
    chk({name, "_busy_cycles"}, W'(nb), W'(lat));
    chk({name, "_hi"}, hi, e_hi);
    chk({name, "_lo"}, lo, e_lo);
    m_hi = e_hi;
    m_lo = e_lo;
    @(negedge clk);
    chk({name, "_done_pulse"}, W'(done), W'(0));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    op    = 2'b00;
    sr    = '0;
    tg    = '0;
    wdata = '0;

    vt[0]  = '{2'b00, 32'h0000_0010, 32'h0000_0010,
               32'h0000_0000, 32'h0000_0100, 1'b0};
    vt[1]  = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002,
               32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vt[2]  = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0002,
               32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
    vt[3]  = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vt[4]  = '{2'b10, 32'h0000_0007, 32'h0000_0003,
               32'h0000_0001, 32'h0000_0002, 1'b0};
    vt[5]  = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h8000_0000, 1'b0};
    vt[6]  = '{2'b10, 32'h1234_5678, 32'h0000_0000,
               32'h1234_5678, 32'hFFFF_FFFF, 1'b0};
    vt[7]  = '{2'b00, 32'h0000_0003, 32'h0000_0005,
               32'h0000_0000, 32'h0000_000F, 1'b0};
    vt[8]  = '{2'b01, 32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, 32'h0000_0000, 1'b0};
    vt[9]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vt[10] = '{2'b11, 32'h0000_0007, 32'hFFFF_FFFE,
               32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vt[11] = '{2'b11, 32'hFFFF_FFFB, 32'h0000_0000,
               32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0};
    vt[12] = '{2'b00, 32'h0000_1234, 32'h0000_0000,
               32'h0000_0000, 32'h0000_0000, 1'b1};
    vt[13] = '{2'b10, 32'h0000_0000, 32'h0000_0005,
               32'h0000_0000, 32'h0000_0000, 1'b1};
    vt[14] = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0005,
               32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_hi", hi, '0);
    chk("reset_lo", lo, '0);
    chk("reset_busy", W'(busy), W'(0));
    chk("reset_done", W'(done), W'(0));

    for (int i = 0; i < 15; i++) begin
      issue(vt[i].op, vt[i].sr, vt[i].tg);
      chk($sformatf("v%0d_hi_held", i), hi, m_hi);
      wait_result($sformatf("v%0d", i), lat_of(vt[i].skip),
                  0, vt[i].e_hi, vt[i].e_lo);
    end

    // mthi alone, then mthi+mtlo together
    @(negedge clk);
    mthi  = 1'b1;
    wdata = 32'hAAAA_0000;
    @(negedge clk);
    mthi  = 1'b0;
    chk("mthi_idle", hi, 32'hAAAA_0000);
    chk("mthi_lo_kept", lo, m_lo);
    m_hi  = 32'hAAAA_0000;
    mthi  = 1'b1;
    mtlo  = 1'b1;
    wdata = 32'h1234_0000;
    @(negedge clk);
    mthi  = 1'b0;
    mtlo  = 1'b0;
    chk("mthilo_hi", hi, 32'h1234_0000);
    chk("mthilo_lo", lo, 32'h1234_0000);
    m_hi = 32'h1234_0000;
    m_lo = 32'h1234_0000;

    // mtlo and a second start while busy are both ignored
    issue(2'b00, 32'd3, 32'd5);
    mtlo  = 1'b1;
    wdata = 32'hDEAD_BEEF;
    start = 1'b1;
    op    = 2'b10;
    sr    = 32'd100;
    tg    = 32'd7;
    @(negedge clk);
    mtlo  = 1'b0;
    start = 1'b0;
    chk("mtlo_busy_lo", lo, m_lo);
    wait_result("busy_start", FULL, 1, 32'h0, 32'd15);

    // start with mtlo in the same cycle: move dropped
    @(negedge clk);
    start = 1'b1;
    op    = 2'b00;
    sr    = 32'd2;
    tg    = 32'd3;
    mtlo  = 1'b1;
    wdata = 32'h1111_1111;
    @(negedge clk);
    start = 1'b0;
    mtlo  = 1'b0;
    chk("start_mtlo_lo", lo, m_lo);
    wait_result("start_mtlo", FULL, 0, 32'h0, 32'd6);

    // reset in the middle of CALC
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_hi", hi, '0);
    chk("rst_mid_lo", lo, '0);
    chk("rst_mid_busy", W'(busy), W'(0));
    chk("rst_mid_done", W'(done), W'(0));
    m_hi = '0;
    m_lo = '0;
    begin
      int seen;
      seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (done || busy) seen++;
      end
      chk("rst_mid_quiet", W'(seen), W'(0));
    end
    issue(2'b00, 32'd3, 32'd5);
    wait_result("after_rst", FULL, 0, 32'h0, 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==",
             applied, miscompares);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide sequencer for the MIPS core. It accepts mult/multu/div/divu requests and runs an iterative shift-add multiply or a restoring divide over several cycles.
- Owns the architectural HI/LO registers and serves mthi/mtlo writes.
- Exposes busy/done so the pipeline can stall on mfhi/mflo while an operation is in flight.
- Sits beside the combinational ALU in EX and takes its operands from the same sr/tg buses.

Parameters:
- WIDTH, 32, operand/HI/LO width; all test values assume 32.
- STEPS_PER_CYCLE, 1, iterations per CALC cycle; legal values 1, 2, 4, and it must divide WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request pulse; sampled only in IDLE
- op  input  2  00 multu, 01 mult, 10 divu, 11 div
- sr  input  WIDTH  operand A (multiplicand / dividend)
- tg  input  WIDTH  operand B (multiplier / divisor)
- mthi  input  1  write wdata to HI
- mtlo  input  1  write wdata to LO
- wdata  input  WIDTH  mthi/mtlo data
- hi  output  WIDTH  HI register (product upper / remainder)
- lo  output  WIDTH  LO register (product lower / quotient)
- busy  output  1  operation in flight; pipeline stalls mfhi/mflo/mult/div
- done  output  1  one-cycle pulse: HI/LO just updated by an operation

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: hi=0, lo=0, busy=0, done=0, state=IDLE. Reset mid-operation aborts the operation with no HI/LO update.
- FSM states: IDLE, CALC, FIX.
- IDLE -> CALC on start. At that edge, latch op and operands; for signed ops, latch |sr| and |tg| plus sign flags; clear the counter and busy=1.
- CALC: perform STEPS_PER_CYCLE iterations per cycle. After WIDTH/STEPS_PER_CYCLE cycles, go to FIX.
- FIX: apply sign correction, write hi/lo, done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency with STEPS_PER_CYCLE=1: start sampled at edge E0; busy=1 from E0 to E33; hi/lo valid and done=1 after E33. Total WIDTH+1 edges. General case: WIDTH/STEPS_PER_CYCLE+1 edges.
- Multiply: 2*WIDTH-bit product; hi=upper half, lo=lower half.
- mult sign correction: negate the full 64-bit product when sign(sr) xor sign(tg).
- Divide: restoring algorithm on magnitudes; lo=quotient, hi=remainder.
- div sign rules: quotient negated when signs differ; remainder takes the sign of the dividend (truncation toward zero).
- 0x80000000 div 0xFFFFFFFF -> lo=0x80000000, hi=0. This falls out of the magnitude algorithm with no special case.
- Divide by zero (tg==0, div or divu): lo=0xFFFFFFFF, hi=sr unmodified. Full latency, no exception.
- start while busy: ignored (pipeline must not issue it; no queueing).
- mthi/mtlo: honored only in IDLE, written at the next edge; ignored while busy.
- start and mthi/mtlo in the same IDLE cycle: start wins, and the move is dropped.
- mthi and mtlo together: both are written.
- hi/lo hold their previous values throughout CALC; there are no intermediate values on outputs.
- Outputs are registered only; no combinational path from inputs to outputs.

Optional Feature:
- Macro: MDU_ZERO_SKIP_EN.
- Defined: at start, if (mult/multu and (sr==0 or tg==0)) or (div/divu with sr==0 and tg!=0), go IDLE -> FIX directly. FIX writes hi=0, lo=0 and pulses done after E1, so busy is high for one cycle.
- Undefined: all operations take full latency regardless of operand values.

Test Plan:
- multu sr=0x00000010, tg=0x00000010 -> after 33 cycles, done pulse, hi=0x00000000, lo=0x00000100; busy high exactly 33 cycles.
- mult sr=0xFFFFFFFF (-1), tg=0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE. Then multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- div sr=-7 (0xFFFFFFF9), tg=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu sr=7, tg=3 -> lo=2, hi=1. div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu sr=0x12345678, tg=0 -> lo=0xFFFFFFFF, hi=0x12345678. With MDU_ZERO_SKIP_EN, multu tg=0 -> done after 1 edge, hi=lo=0.
- mthi wdata=0xAAAA0000 in IDLE -> hi=0xAAAA0000 next edge. mtlo during CALC -> lo unchanged. start plus mtlo in the same cycle -> mtlo dropped; second start during busy ignored.
- Assert rst at CALC cycle 10 -> next edge hi=lo=0, busy=0, done=0, no done pulse. A following multu 3*5 -> lo=15.
